data_mem_access_ctrl: RTL and testbench
=======================================

Name: data_mem_access_ctrl

Overview:
- Responder end of the main-decoder memory control interface (MemRead/MemWrite).
- Sits in the MEM stage between the datapath and a variable-latency data memory.
- Turns a level-held MemRead/MemWrite plus an address into a single req/ack transaction on the memory port.
- Stalls the pipeline until the transaction completes, returns load data, and flags misaligned, conflicting or timed-out accesses.

Parameters:
- ADDR_W, 32, address width (byte address).
- DATA_W, 32, data width.
- TIMEOUT, 15, maximum BUSY cycles to wait for mem_ack before abort; range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  load request from decoder, held while stalled.
- MemWrite  in  1  store request from decoder, held while stalled.
- addr  in  ADDR_W  byte address from ALU.
- wdata  in  DATA_W  store data.
- rdata  out  DATA_W  registered load data.
- stall  out  1  combinational hold for PC/IF/ID/EX/MEM registers.
- err  out  1  one-cycle error pulse.
- mem_req  out  1  registered request to memory.
- mem_we  out  1  registered write enable, qualified by mem_req.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory.

Behaviour:
- Reset (async, active-high): state=IDLE, timeout counter=0, and every output register cleared: rdata, err, mem_req, mem_we, mem_addr, mem_wdata all 0.
- Combinational: stall=0 while reset is asserted.
- States: IDLE, BUSY, DONE.
- Request classification in IDLE, where req = MemRead|MemWrite:
  - Legal: exactly one of MemRead/MemWrite high and addr[1:0]==0.
  - Conflict: MemRead&MemWrite both high.
  - Misaligned: req high and addr[1:0]!=0.
- IDLE:
  - Legal request: stall=1 combinationally in this cycle. Latch mem_addr=addr, mem_wdata=wdata, mem_we=MemWrite. Set mem_req=1 and go to BUSY.
  - Conflict or misaligned: no memory access. err=1 on the next cycle for one cycle, stall=0, stay in IDLE.
  - No request: stall=0.
- BUSY:
  - stall=1 and mem_req held at 1.
  - On mem_ack: drop mem_req. If the transaction is a read (mem_we=0), capture rdata=mem_rdata. Go to DONE.
  - No ack: increment the counter. When the counter reaches TIMEOUT with no ack, drop mem_req, set rdata=0 for reads, pulse err, and go to DONE.
  - mem_ack arriving in the same cycle the counter hits TIMEOUT counts as success; no err.
- DONE:
  - stall=0, so the stalled instruction advances at the end of this cycle.
  - MemRead/MemWrite are ignored this cycle (they still belong to the same instruction).
  - Clear the counter and go to IDLE unconditionally.
- Latency: request seen in cycle 0, mem_req=1 from cycle 1, ack in cycle 1+k (k≥0), DONE in cycle 2+k. The pipeline sees 2+k stall cycles.
- Back-to-back memory instructions: the second request is evaluated in the IDLE cycle after DONE, giving a minimum 3-cycle spacing.
- rdata holds its last value across stores, errors-free idle periods and stalls. It changes only on a read ack, a read timeout (to 0), or reset.
- mem_ack outside BUSY is ignored and must not change rdata.
- Reset mid-transaction: immediate return to IDLE with mem_req=0. No err pulse is generated.

Test Plan:
1. Load with 0-wait ack: MemRead=1, addr=0x10. Memory acks in the first cycle mem_req is high, with mem_rdata=0xDEADBEEF. Expect stall high for 2 cycles, mem_req high for 1 cycle with mem_we=0, then rdata=0xDEADBEEF and stall=0 in DONE.
2. Store with 3-cycle wait: MemWrite=1, addr=0x24, wdata=0x12345678, ack after 3 BUSY cycles. Expect mem_we=1, mem_addr=0x24, mem_wdata=0x12345678, stall high for 5 cycles, rdata unchanged, err=0.
3. Misaligned and conflict: MemRead=1 with addr=0x13 gives err pulse of 1 cycle, stall=0, mem_req never high. MemRead=MemWrite=1 with addr=0x20 gives the same result.
4. Timeout: MemRead=1, addr=0x40, no ack. Expect mem_req high for exactly TIMEOUT=15 cycles, then err=1 for 1 cycle, rdata=0, and stall low in DONE.
5. Back-to-back loads: 0x10 then 0x14, each acked immediately. Expect two separate mem_req pulses with 3-cycle spacing and rdata updated in order. A stray mem_ack while in IDLE leaves rdata unchanged.
6. Reset mid-BUSY: assert reset 2 cycles into a load. Expect mem_req=0, stall=0 and rdata=0 immediately, no err, and the next load completing normally.

Source files
------------

// File: rtl/data_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_access_ctrl
//  Purpose  : MEM-stage data memory access controller. Converts level-held
//             MemRead/MemWrite into one req/ack transaction on the memory
//             port, stalls the pipeline until it completes, returns load
//             data and flags misaligned, conflicting or timed-out accesses.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_access_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15     // 1..255 BUSY cycles before abort
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Counter value in the last BUSY cycle allowed before the access aborts.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0] state;
   logic [7:0] cnt;
   logic       req;
   logic       legal;
   logic       bad;

   assign req   = MemRead | MemWrite;
   assign legal = (MemRead ^ MemWrite) && (addr[1:0] == 2'b00);
   // Anything requested but not legal is either a conflict or misaligned.
   assign bad   = req && !legal;

   // Pipeline hold: from the cycle a legal request is seen until the ack
   // (or abort) cycle; DONE releases the instruction.
   assign stall = !reset && ((state == BUSY) || ((state == IDLE) && legal));

   // Transaction sequencing, memory port registers and load data capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         rdata     <= '0;
         err       <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (legal) begin
                  mem_addr  <= addr;
                  mem_wdata <= wdata;
                  mem_we    <= MemWrite;
                  mem_req   <= 1'b1;
                  cnt       <= 8'd0;
                  state     <= BUSY;
               end else if (bad) begin
                  err <= 1'b1;
               end
            end
            BUSY: begin
               // An ack always wins, even on the final allowed cycle.
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (!mem_we) begin
                     rdata <= mem_rdata;
                  end
                  state <= DONE;
               end else if (cnt == CNT_LAST) begin
                  mem_req <= 1'b0;
                  err     <= 1'b1;
                  if (!mem_we) begin
                     rdata <= '0;
                  end
                  state <= DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               // Requests seen here still belong to the finishing instruction.
               cnt   <= 8'd0;
               state <= IDLE;
            end
            default: begin
               mem_req <= 1'b0;
               cnt     <= 8'd0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_access_ctrl
//  Purpose  : Directed self-checking bench for data_mem_access_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int errors = 0;
   int checks = 0;

   data_mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .stall     (stall),
      .err       (err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1 ns later.

   task automatic test_reset;
      reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; addr = 32'h10;
      wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
      @(negedge clk); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b expected 0", mem_req); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      checks++; if (err !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         errors++; $display("FAIL reset_regs: err=%0b we=%0b addr=%h wdata=%h expected all 0", err, mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk); reset = 1'b0; MemRead = 1'b0; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %0b expected 0", stall); end
   endtask

   task automatic test_load_zero_wait;
      @(negedge clk); MemRead = 1'b1; addr = 32'h10; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load0_req_stall: got %0b expected 1", stall); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL load0_req_early: got %0b expected 0", mem_req); end
      @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load0_busy_stall: got %0b expected 1", stall); end
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
         errors++; $display("FAIL load0_busy_req: req=%0b we=%0b expected req=1 we=0", mem_req, mem_we);
      end
      checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL load0_addr: got %h expected 00000010", mem_addr); end
      @(negedge clk); mem_ack = 1'b0; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load0_done_stall: got %0b expected 0", stall); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL load0_done_req: got %0b expected 0", mem_req); end
      checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load0_rdata: got %h expected deadbeef", rdata); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL load0_err: got %0b expected 0", err); end
      @(negedge clk); MemRead = 1'b0; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load0_after_stall: got %0b expected 0", stall); end
   endtask

   task automatic test_store_wait;
      int stall_cnt = 0;
      @(negedge clk); MemWrite = 1'b1; addr = 32'h24; wdata = 32'h12345678; #1;
      if (stall) stall_cnt++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); mem_ack = (i == 3); mem_rdata = 32'hBAD0BAD0; #1;
         if (stall) stall_cnt++;
         checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL store_req_cycle%0d: got %0b expected 1", i, mem_req); end
         if (i == 0) begin
            checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h24 || mem_wdata !== 32'h12345678) begin
               errors++; $display("FAIL store_port: we=%0b addr=%h wdata=%h expected 1/00000024/12345678", mem_we, mem_addr, mem_wdata);
            end
         end
      end
      @(negedge clk); mem_ack = 1'b0; #1;
      if (stall) stall_cnt++;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL store_err: got %0b expected 0", err); end
      checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_rdata_kept: got %h expected deadbeef", rdata); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL store_done_req: got %0b expected 0", mem_req); end
      checks++; if (stall_cnt != 5) begin errors++; $display("FAIL store_stall_cycles: got %0d expected 5", stall_cnt); end
      @(negedge clk); MemWrite = 1'b0;
   endtask

   task automatic test_misaligned_conflict;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         MemRead = 1'b1; MemWrite = (k == 1); addr = (k == 0) ? 32'h13 : 32'h20; #1;
         checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL bad%0d_req_cycle: stall=%0b req=%0b expected 0/0", k, stall, mem_req);
         end
         @(negedge clk); MemRead = 1'b0; MemWrite = 1'b0; #1;
         checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad%0d_err_pulse: got %0b expected 1", k, err); end
         checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL bad%0d_no_access: req=%0b stall=%0b expected 0/0", k, mem_req, stall);
         end
         @(negedge clk); #1;
         checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad%0d_err_width: got %0b expected 0", k, err); end
      end
   endtask

   task automatic test_timeout;
      int  req_cnt = 0;
      bit  done = 1'b0;
      @(negedge clk); MemRead = 1'b1; addr = 32'h40; mem_ack = 1'b0; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL tmo_req_stall: got %0b expected 1", stall); end
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk); #1;
         if (mem_req) begin
            req_cnt++;
         end else begin
            done = 1'b1;
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %0b expected 1", err); end
            checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata: got %h expected 0", rdata); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL tmo_done_stall: got %0b expected 0", stall); end
         end
      end
      checks++; if (!done) begin errors++; $display("FAIL tmo_never_ended: mem_req still high after 40 cycles, expected low"); end
      checks++; if (req_cnt != 15) begin errors++; $display("FAIL tmo_req_cycles: got %0d expected 15", req_cnt); end
      @(negedge clk); MemRead = 1'b0; #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_width: got %0b expected 0", err); end
   endtask

   task automatic test_back_to_back;
      int first_req = -1;
      int second_req = -1;
      bit prev_req = 1'b0;
      for (int step = 0; step < 8; step++) begin
         @(negedge clk);
         case (step)
            0: begin MemRead = 1'b1; addr = 32'h10; mem_ack = 1'b0; end
            1: begin mem_ack = 1'b1; mem_rdata = 32'h11111111; end
            2: begin mem_ack = 1'b0; end
            3: begin addr = 32'h14; end
            4: begin mem_ack = 1'b1; mem_rdata = 32'h22222222; end
            5: begin mem_ack = 1'b0; end
            6: begin MemRead = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h33333333; end
            default: begin mem_ack = 1'b0; end
         endcase
         #1;
         if (mem_req && !prev_req) begin
            if (first_req < 0) first_req = step;
            else if (second_req < 0) second_req = step;
         end
         prev_req = mem_req;
         case (step)
            0, 3: begin
               checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_step%0d_stall: got %0b expected 1", step, stall); end
            end
            1: begin
               checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL b2b_addr1: got %h expected 00000010", mem_addr); end
            end
            2: begin
               checks++; if (rdata !== 32'h11111111 || stall !== 1'b0) begin
                  errors++; $display("FAIL b2b_done1: rdata=%h stall=%0b expected 11111111/0", rdata, stall);
               end
            end
            4: begin
               checks++; if (mem_addr !== 32'h14) begin errors++; $display("FAIL b2b_addr2: got %h expected 00000014", mem_addr); end
            end
            5: begin
               checks++; if (rdata !== 32'h22222222) begin errors++; $display("FAIL b2b_rdata2: got %h expected 22222222", rdata); end
            end
            7: begin
               checks++; if (rdata !== 32'h22222222 || err !== 1'b0 || stall !== 1'b0) begin
                  errors++; $display("FAIL b2b_stray_ack: rdata=%h err=%0b stall=%0b expected 22222222/0/0", rdata, err, stall);
               end
            end
            default: ;
         endcase
      end
      checks++; if (first_req != 1 || second_req != 4) begin
         errors++; $display("FAIL b2b_spacing: req rises at steps %0d,%0d expected 1,4", first_req, second_req);
      end
   endtask

   task automatic test_reset_mid_busy;
      @(negedge clk); MemRead = 1'b1; addr = 32'h50; mem_ack = 1'b0; #1;
      @(negedge clk); #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_req: got %0b expected 1", mem_req); end
      @(negedge clk); reset = 1'b1; #1;
      checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL rst_mid_outputs: req=%0b stall=%0b err=%0b expected 0/0/0", mem_req, stall, err);
      end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 0", rdata); end
      @(negedge clk); reset = 1'b0; #1;
      checks++; if (err !== 1'b0 || stall !== 1'b1) begin
         errors++; $display("FAIL rst_mid_retry: err=%0b stall=%0b expected 0/1", err, stall);
      end
      @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h50) begin
         errors++; $display("FAIL rst_mid_retry_port: req=%0b addr=%h expected 1/00000050", mem_req, mem_addr);
      end
      @(negedge clk); mem_ack = 1'b0; #1;
      checks++; if (rdata !== 32'hCAFEF00D || stall !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL rst_mid_retry_done: rdata=%h stall=%0b err=%0b expected cafef00d/0/0", rdata, stall, err);
      end
      @(negedge clk); MemRead = 1'b0;
   endtask

   initial begin
      test_reset;
      test_load_zero_wait;
      test_store_wait;
      test_misaligned_conflict;
      test_timeout;
      test_back_to_back;
      test_reset_mid_busy;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at 100000 ns, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
